// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// Holds the fetch FSM state encoding and the saturating counter helper.
package mips_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned ADDR_W = 32;

   localparam logic [WORD_W-1:0] NOP_INSTR_C = 32'h0000_0000;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t S_REQ   = 2'd0;
   localparam fetch_state_t S_HOLD  = 2'd1;
   localparam fetch_state_t S_DRAIN = 2'd2;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry instruction buffer; catches a returned fetch while IF/ID is frozen.
// Clear takes priority over load.
module fetch_hold_buf
   import mips_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout,
   output logic              valid
);

   logic [WORD_W-1:0] data_q;
   logic              valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (clear) begin
         valid_q <= 1'b0;
      end else if (load) begin
         data_q  <= din;
         valid_q <= 1'b1;
      end
   end

   assign dout  = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, req/ready instruction fetch, IF/ID register, stall/flush handling.
// Define FETCH_PERF_EN to build the saturating stall/flush performance counters.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [WORD_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_write,
   input  logic              if_id_write,
   input  logic              flush,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [WORD_W-1:0] imem_rdata,
   output logic [WORD_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc4,
   output logic              if_id_valid,
   output logic              fetch_stall,
   output logic [31:0]       perf_stalls,
   output logic [31:0]       perf_flushes
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
   logic [WORD_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pc4_q, pc4_d;
   logic              valid_q, valid_d;
   logic              buf_load, buf_clear, buf_valid;
   logic [WORD_W-1:0] buf_data;
   logic [ADDR_W-1:0] pc_plus4;
   logic              advance;

   assign advance  = if_id_write & pc_write;
   assign pc_plus4 = pc_q + 32'd4;

   fetch_hold_buf u_hold_buf (
      .clk   (clk),
      .rst   (rst),
      .load  (buf_load),
      .clear (buf_clear),
      .din   (imem_rdata),
      .dout  (buf_data),
      .valid (buf_valid)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      valid_d      = valid_q;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;

      if (flush) begin
         instr_d   = NOP_INSTR;
         valid_d   = 1'b0;
         pc_d      = branch_target;
         buf_clear = 1'b1;
         case (state_q)
            S_REQ: begin
               // An unanswered request must still be consumed before refetching
               if (!imem_ready) begin
                  state_d      = S_DRAIN;
                  drain_addr_d = pc_q;
               end
            end
            S_DRAIN: state_d = S_DRAIN;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_ready) begin
                  if (advance) begin
                     instr_d = imem_rdata;
                     pc4_d   = pc_plus4;
                     valid_d = 1'b1;
                     pc_d    = pc_plus4;
                  end else begin
                     buf_load = 1'b1;
                     state_d  = S_HOLD;
                  end
               end else if (if_id_write) begin
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
               end
            end
            S_HOLD: begin
               if (advance && buf_valid) begin
                  instr_d   = buf_data;
                  pc4_d     = pc_plus4;
                  valid_d   = 1'b1;
                  pc_d      = pc_plus4;
                  buf_clear = 1'b1;
                  state_d   = S_REQ;
               end
            end
            S_DRAIN: begin
               if (if_id_write) begin
                  instr_d = NOP_INSTR;
                  valid_d = 1'b0;
               end
               if (imem_ready) begin
                  state_d = S_REQ;
               end
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         instr_q      <= NOP_INSTR;
         pc4_q        <= '0;
         valid_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         valid_q      <= valid_d;
      end
   end

   assign imem_req    = ~rst & (state_q != S_HOLD);
   assign imem_addr   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
   assign fetch_stall = (state_q == S_DRAIN) | ((state_q == S_REQ) & ~imem_ready);
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_valid = valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] stalls_q, flushes_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stalls_q  <= '0;
         flushes_q <= '0;
      end else begin
         if (fetch_stall || !if_id_write) stalls_q <= sat_inc(stalls_q);
         if (flush) flushes_q <= sat_inc(flushes_q);
      end
   end

   assign perf_stalls  = stalls_q;
   assign perf_flushes = flushes_q;
`else
   assign perf_stalls  = '0;
   assign perf_flushes = '0;
`endif

`ifndef SYNTHESIS
   a_stall_ctrl_match: assert property (@(posedge clk) disable iff (rst)
      pc_write == if_id_write);
   a_target_aligned: assert property (@(posedge clk) disable iff (rst)
      flush |-> (branch_target[1:0] == 2'b00));
`endif

endmodule
